// File: rtl/disco_pkg.sv
// Shared types and constants for the disco TRM core; this slice adds the
// boot-time program loader state type and frame constants.
package disco;

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHK,
    ST_RUN,
    ST_ERR
  } loader_state_t;

  localparam int unsigned LOADER_LEN_BYTES = 2;
  localparam int unsigned LOADER_CHK_BYTES = 1;

endpackage

// File: rtl/disco_word_packer.sv
// Assembles little-endian stream bytes into IW-bit words and flags the
// byte that completes each word.
module disco_word_packer
  import disco::*;
#(
  parameter int unsigned IW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          shift_i,
  input  logic [7:0]    byte_i,
  output logic [IW-1:0] word_o,
  output logic          last_o
);

  localparam int unsigned BPW = IW / 8;
  localparam int unsigned BW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IW-1:0] word_q, word_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  // word_o carries the current byte already in place, so the top module can
  // register the completed word on the same cycle the last byte is accepted.
  always_comb begin
    word_d                       = word_q;
    word_d[int'(bcnt_q)*8 +: 8]  = byte_i;
    word_o                       = word_d;
    last_o                       = (bcnt_q == BW'(BPW - 1));
    bcnt_d                       = bcnt_q;
    if (shift_i) begin
      bcnt_d = last_o ? '0 : bcnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      bcnt_q <= '0;
    end else if (clr_i) begin
      word_q <= '0;
      bcnt_q <= '0;
    end else if (shift_i) begin
      word_q <= word_d;
      bcnt_q <= bcnt_d;
    end
  end

endmodule

// File: rtl/disco_prog_loader.sv
// Boot loader: length-prefixed byte frame -> imem writes from address 0, core
// held in reset until the image is in. Optional XOR checksum: DISCO_LOADER_CHECKSUM_EN.
module disco_prog_loader
  import disco::*;
#(
  parameter int unsigned IW = 32,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          reload,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          core_rst_n,
  output logic          done,
  output logic          err
);

  localparam logic [16:0] CAP = 17'(1) << AW;
`ifdef DISCO_LOADER_CHECKSUM_EN
  localparam loader_state_t ST_END = ST_CHK;
`else
  localparam loader_state_t ST_END = ST_RUN;
`endif

  loader_state_t state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] wdata_q, wdata_d;
  logic          core_rst_n_q;
`ifdef DISCO_LOADER_CHECKSUM_EN
  logic [7:0]    acc_q, acc_d;
`endif

  logic          accept;
  logic          pk_shift, pk_clr, pk_last;
  logic [IW-1:0] pk_word;
  logic [16:0]   n_len, wcnt_inc;

  disco_word_packer #(.IW(IW)) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (pk_clr),
    .shift_i (pk_shift),
    .byte_i  (in_data),
    .word_o  (pk_word),
    .last_o  (pk_last)
  );

  assign in_ready = (state_q != ST_RUN) && (state_q != ST_ERR);
  assign accept   = in_valid && in_ready;
  assign n_len    = {1'b0, in_data, len_q[7:0]};
  assign wcnt_inc = 17'(wcnt_q) + 17'd1;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pk_shift = 1'b0;
    pk_clr   = 1'b0;
`ifdef DISCO_LOADER_CHECKSUM_EN
    acc_d    = acc_q;
`endif
    unique case (state_q)
      ST_LEN_LO: if (accept) begin
        len_d[7:0] = in_data;
        state_d    = ST_LEN_HI;
      end
      ST_LEN_HI: if (accept) begin
        len_d[15:8] = in_data;
        if (n_len > CAP)       state_d = ST_ERR;
        else if (n_len == '0)  state_d = ST_END;
        else                   state_d = ST_DATA;
      end
      ST_DATA: if (accept) begin
        pk_shift = 1'b1;
`ifdef DISCO_LOADER_CHECKSUM_EN
        acc_d    = acc_q ^ in_data;
`endif
        if (pk_last) begin
          we_d    = 1'b1;
          addr_d  = wcnt_q[AW-1:0];
          wdata_d = pk_word;
          wcnt_d  = wcnt_inc[AW:0];
          if (wcnt_inc == {1'b0, len_q}) state_d = ST_END;
        end
      end
`ifdef DISCO_LOADER_CHECKSUM_EN
      ST_CHK: if (accept) begin
        state_d = (acc_q == in_data) ? ST_RUN : ST_ERR;
      end
`endif
      ST_RUN, ST_ERR: if (reload) begin
        state_d = ST_LEN_LO;
        wcnt_d  = '0;
        pk_clr  = 1'b1;
`ifdef DISCO_LOADER_CHECKSUM_EN
        acc_d   = '0;
`endif
      end
      default: state_d = ST_LEN_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LEN_LO;
      len_q        <= '0;
      wcnt_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
`ifdef DISCO_LOADER_CHECKSUM_EN
      acc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wcnt_q       <= wcnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_rst_n_q <= (state_q == ST_RUN);
`ifdef DISCO_LOADER_CHECKSUM_EN
      acc_q        <= acc_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign done       = (state_q == ST_RUN);
  assign err        = (state_q == ST_ERR);

endmodule

// File: tb/tb_disco_prog_loader.sv
// Directed bench for disco_prog_loader with IW=32, AW=4; checksum scenarios
// follow DISCO_LOADER_CHECKSUM_EN.
module tb_disco_prog_loader;

  localparam int unsigned IW = 32;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          reload = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          core_rst_n;
  logic          done;
  logic          err;

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] log_addr[$];
  logic [IW-1:0] log_data[$];
  int            we_run = 0;
  int            we_max = 0;

  disco_prog_loader #(.IW(IW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
      we_run = we_run + 1;
      if (we_run > we_max) we_max = we_run;
    end else begin
      we_run = 0;
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    we_max = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reload   = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL send_byte_timeout in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input bit stall);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      if (stall) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_good_writes(input string tag);
    n_vec++;
    if (log_addr.size() !== 2) begin
      n_err++; $display("FAIL %s_write_count got %0d required 2", tag, log_addr.size());
    end else begin
      n_vec++;
      if (log_addr[0] !== 4'd0 || log_data[0] !== 32'h12345678) begin
        n_err++; $display("FAIL %s_word0 got %0d:%h required 0:12345678", tag, log_addr[0], log_data[0]);
      end
      n_vec++;
      if (log_addr[1] !== 4'd1 || log_data[1] !== 32'hDEADBEEF) begin
        n_err++; $display("FAIL %s_word1 got %0d:%h required 1:deadbeef", tag, log_addr[1], log_data[1]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (in_ready !== 1'b1)    begin n_err++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
    n_vec++; if (imem_we !== 1'b0)     begin n_err++; $display("FAIL rst_imem_we got %b required 0", imem_we); end
    n_vec++; if (imem_addr !== 4'd0)   begin n_err++; $display("FAIL rst_imem_addr got %h required 0", imem_addr); end
    n_vec++; if (imem_wdata !== 32'd0) begin n_err++; $display("FAIL rst_imem_wdata got %h required 0", imem_wdata); end
    n_vec++; if (core_rst_n !== 1'b0)  begin n_err++; $display("FAIL rst_core_rst_n got %b required 0", core_rst_n); end
    n_vec++; if (done !== 1'b0)        begin n_err++; $display("FAIL rst_done got %b required 0", done); end
    n_vec++; if (err !== 1'b0)         begin n_err++; $display("FAIL rst_err got %b required 0", err); end
  endtask

  task automatic test_good_image(input bit stall);
    logic [7:0] f[$];
    string tag;
    tag = stall ? "stall" : "good";
    do_reset();
    f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef DISCO_LOADER_CHECKSUM_EN
    f.push_back(8'h2A);
`endif
    send_frame(f, 1'b0 ^ stall);
    if (stall) begin
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL %s_done got %b required 1", tag, done); end
    end else begin
      n_vec++; if (done !== 1'b1)       begin n_err++; $display("FAIL %s_done_next_cycle got %b required 1", tag, done); end
      n_vec++; if (core_rst_n !== 1'b0) begin n_err++; $display("FAIL %s_core_rst_lag got %b required 0", tag, core_rst_n); end
    end
    idle(2);
    check_good_writes(tag);
    n_vec++; if (we_max !== 1)          begin n_err++; $display("FAIL %s_we_width got %0d required 1", tag, we_max); end
    n_vec++; if (done !== 1'b1)         begin n_err++; $display("FAIL %s_done got %b required 1", tag, done); end
    n_vec++; if (core_rst_n !== 1'b1)   begin n_err++; $display("FAIL %s_core_rst_n got %b required 1", tag, core_rst_n); end
    n_vec++; if (in_ready !== 1'b0)     begin n_err++; $display("FAIL %s_in_ready got %b required 0", tag, in_ready); end
    n_vec++; if (err !== 1'b0)          begin n_err++; $display("FAIL %s_err got %b required 0", tag, err); end
  endtask

`ifdef DISCO_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    logic [7:0] f[$];
    do_reset();
    f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
    send_frame(f, 1'b0);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL badchk_err_next_cycle got %b required 1", err); end
    idle(3);
    check_good_writes("badchk");
    n_vec++; if (err !== 1'b1)        begin n_err++; $display("FAIL badchk_err got %b required 1", err); end
    n_vec++; if (done !== 1'b0)       begin n_err++; $display("FAIL badchk_done got %b required 0", done); end
    n_vec++; if (core_rst_n !== 1'b0) begin n_err++; $display("FAIL badchk_core_rst_n got %b required 0", core_rst_n); end
    n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL badchk_in_ready got %b required 0", in_ready); end
  endtask
`endif

  task automatic test_oversize();
    do_reset();
    send_byte(8'h11);
    send_byte(8'h00);
    n_vec++; if (err !== 1'b1)      begin n_err++; $display("FAIL oversize_err got %b required 1", err); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL oversize_in_ready got %b required 0", in_ready); end
    idle(3);
    n_vec++; if (log_addr.size() !== 0) begin n_err++; $display("FAIL oversize_writes got %0d required 0", log_addr.size()); end
    n_vec++; if (core_rst_n !== 1'b0)   begin n_err++; $display("FAIL oversize_core_rst_n got %b required 0", core_rst_n); end
  endtask

  task automatic test_full_capacity();
    logic [7:0] f[$];
    int bad = 0;
    do_reset();
    f = '{8'h10, 8'h00};
    for (int unsigned j = 0; j < 64; j++) f.push_back(8'(j));
`ifdef DISCO_LOADER_CHECKSUM_EN
    f.push_back(8'h00);
`endif
    send_frame(f, 1'b0);
    idle(2);
    n_vec++;
    if (log_addr.size() !== 16) begin
      n_err++; $display("FAIL full_write_count got %0d required 16", log_addr.size());
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        logic [31:0] exp_w;
        exp_w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        if (log_addr[i] !== 4'(i) || log_data[i] !== exp_w) begin
          bad++;
          $display("FAIL full_word%0d got %0d:%h required %0d:%h", i, log_addr[i], log_data[i], i, exp_w);
        end
      end
      n_vec++; if (bad != 0) n_err++;
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL full_done got %b required 1", done); end
  endtask

  task automatic test_reset_midload();
    logic [7:0] f[$];
    do_reset();
    f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34};
    send_frame(f, 1'b0);
    rst_n = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1)    begin n_err++; $display("FAIL midrst_in_ready got %b required 1", in_ready); end
    n_vec++; if (imem_we !== 1'b0)     begin n_err++; $display("FAIL midrst_imem_we got %b required 0", imem_we); end
    n_vec++; if (imem_addr !== 4'd0)   begin n_err++; $display("FAIL midrst_imem_addr got %h required 0", imem_addr); end
    n_vec++; if (imem_wdata !== 32'd0) begin n_err++; $display("FAIL midrst_imem_wdata got %h required 0", imem_wdata); end
    n_vec++; if (core_rst_n !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_err++; $display("FAIL midrst_status got %b%b%b required 000", core_rst_n, done, err);
    end
    test_good_image(1'b0);
  endtask

  task automatic test_reload();
    logic [7:0] f[$];
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reload_in_ready got %b required 1", in_ready); end
    n_vec++; if (done !== 1'b0)       begin n_err++; $display("FAIL reload_done got %b required 0", done); end
    idle(1);
    n_vec++; if (core_rst_n !== 1'b0) begin n_err++; $display("FAIL reload_core_rst_n got %b required 0", core_rst_n); end
    clear_log();
    send_byte(8'h01);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    f = '{8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
`ifdef DISCO_LOADER_CHECKSUM_EN
    f.push_back(8'h44);
`endif
    send_frame(f, 1'b0);
    idle(2);
    n_vec++;
    if (log_addr.size() !== 1) begin
      n_err++; $display("FAIL reload_write_count got %0d required 1", log_addr.size());
    end else begin
      n_vec++;
      if (log_addr[0] !== 4'd0 || log_data[0] !== 32'h11223344) begin
        n_err++; $display("FAIL reload_word0 got %0d:%h required 0:11223344", log_addr[0], log_data[0]);
      end
    end
    n_vec++; if (done !== 1'b1)       begin n_err++; $display("FAIL reload_done_again got %b required 1", done); end
    n_vec++; if (core_rst_n !== 1'b1) begin n_err++; $display("FAIL reload_core_rst_again got %b required 1", core_rst_n); end
  endtask

  initial begin
    test_reset();
    test_good_image(1'b0);
`ifdef DISCO_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_oversize();
    test_full_capacity();
    test_good_image(1'b1);
    test_reset_midload();
    test_reload();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
